lv_decay: RTL and testbench
===========================

# lv_decay

Synchronous trace-update stage that sits directly upstream of the last-value register. It computes the decayed version of the stored last value from the time elapsed since the previous accepted spike. On each incoming spike it adds a synaptic weight and presents the result as the register's next value, then issues the strobe that latches it. The decay is linear, or exponential when compiled with the macro under Configuration.

## Interface
- p_width, 21, trace/value width (matches the last-value register)
- p_cnt_width, 16, elapsed-tick counter width
- p_decay, 1, linear decay per tick, in LSBs
- p_half_log2, 4, exponential mode: ticks per halving = 2^p_half_log2
- Clock/reset: one clock `i_clk`; reset `i_rst` is synchronous and active-high.
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_tick  in  1  timebase strobe, one cycle per time unit
- i_spike  in  1  input event, single-cycle pulse synchronous to i_clk
- i_lv  in  p_width  current last value from the downstream register
- i_weight  in  p_width  increment applied per spike
- o_addvalue  out  p_width  registered next value for the downstream register
- o_spike_out  out  1  latch strobe to the downstream register
- o_trace  out  p_width  live decayed trace (combinational from i_lv and the counter)
- o_busy  out  1  FSM not in IDLE
- o_sat  out  1  one-cycle pulse: add saturated
- o_drop  out  1  one-cycle pulse: spike discarded

## Operation
- Elapsed counter:
  - Increments on i_tick and saturates at all-ones.
  - Clears to 0 in the cycle o_spike_out rises. Clear wins over a simultaneous tick.
- Linear decay:
  - Compute prod = elapsed*p_decay at width p_cnt_width+p_width.
  - decayed = 0 if prod >= i_lv, else i_lv - prod.
- Add: sum = decayed + i_weight at p_width+1 bits. If sum exceeds 2^p_width-1, the result is all-ones and o_sat pulses.
- FSM states:
  - IDLE: on i_spike, go to CALC.
  - CALC: register decayed; go to ADD.
  - ADD: register the saturated sum into o_addvalue; go to HOLD.
  - HOLD: o_addvalue is stable for one cycle; go to STROBE.
  - STROBE: o_spike_out is high for 2 cycles. Then go to IDLE, or to CALC if pending is set.
- Pending:
  - i_spike while o_busy sets a one-deep pending flag. Pending clears on entry to CALC.
  - i_spike while pending is already set pulses o_drop; the spike is discarded.
  - i_spike in the last STROBE cycle counts as busy and sets pending.
- Reset mid-operation:
  - Takes effect at the next edge: FSM to IDLE.
  - o_spike_out, o_addvalue, counter and pending are all cleared to 0.
  - A strobe already in progress is truncated, not completed.

## Timing
- Reset values: o_addvalue=0, o_spike_out=0, o_busy=0, o_sat=0, o_drop=0. o_trace equals i_lv with the counter at 0.
- i_spike sampled at edge N:
  - CALC runs in cycle N+1.
  - o_addvalue is valid from N+3.
  - o_spike_out is high in cycles N+4 and N+5.
  - o_busy is high from N+1 through N+5.
- o_addvalue never changes while o_spike_out is high, nor in the cycle before it rises.
- i_lv is sampled in CALC. The downstream register updates on the o_spike_out rising edge, which is after CALC.
- Back-to-back spike with pending: the next CALC starts the cycle after STROBE ends. Minimum spike-to-spike service interval is 5 cycles.
- o_sat pulses in the ADD cycle. o_drop pulses in the cycle after the discarded i_spike.

## Configuration
- LV_DECAY_EXP_EN defined: exponential decay.
  - decayed = i_lv >> k, where k = elapsed >> p_half_log2.
  - If k >= p_width, decayed = 0.
  - p_decay is unused.
- LV_DECAY_EXP_EN undefined: linear decay as in Operation.
- FSM, timing and all ports are identical in both builds.

## Structure
- Package lv_pkg holds:
  - the FSM state enum (IDLE, CALC, ADD, HOLD, STROBE);
  - the default width constants (value 21, counter 16);
  - the strobe length constant (2).
- Sub-module lv_decay_calc:
  - Pure combinational decay function of i_lv and elapsed, selected by LV_DECAY_EXP_EN.
  - Drives o_trace; its output is registered in CALC.

## Test plan
- Reset: assert i_rst for 2 cycles mid-idle -> all outputs 0, o_busy=0, counter 0.
- Linear decay: i_lv=1000, 100 ticks, p_decay=1, i_weight=50, spike at N -> o_addvalue=950 at N+3, o_spike_out high N+4..N+5, counter 0 afterwards.
- Underflow and saturation:
  - i_lv=10, 20 ticks, i_weight=7 -> o_addvalue=7.
  - i_lv=2^21-1, no ticks, i_weight=5 -> o_addvalue=all-ones, o_sat pulses once.
- Overlap: spikes at N, N+2, N+3 -> second is pending and processed (CALC at N+6), third raises o_drop at N+4, exactly 2 strobes occur.
- Reset mid-strobe: i_rst at N+4 -> o_spike_out=0 at N+5, pending cleared, no further strobe.
- Exponential (LV_DECAY_EXP_EN, p_half_log2=4): i_lv=1024, 32 ticks, i_weight=0 -> o_addvalue=256; 400 ticks -> 0.

Source files
------------

// File: rtl/lv_pkg.sv
// rtl/lv_pkg.sv - shared state enum and default widths for the lv_decay trace-update stage
package lv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CALC,
      ADD,
      HOLD,
      STROBE
   } lv_state_t;

   localparam int LV_WIDTH      = 21;
   localparam int LV_CNT_WIDTH  = 16;
   localparam int LV_STROBE_LEN = 2;

endpackage

// File: rtl/lv_decay_if.sv
// rtl/lv_decay_if.sv - spike/tick inputs and next-value/strobe outputs of lv_decay
interface lv_decay_if #(
   parameter int p_width = 21
);
   logic               i_tick;
   logic               i_spike;
   logic [p_width-1:0] i_lv;
   logic [p_width-1:0] i_weight;
   logic [p_width-1:0] o_addvalue;
   logic               o_spike_out;
   logic [p_width-1:0] o_trace;
   logic               o_busy;
   logic               o_sat;
   logic               o_drop;

   modport slave (
      input  i_tick, i_spike, i_lv, i_weight,
      output o_addvalue, o_spike_out, o_trace, o_busy, o_sat, o_drop
   );

   modport master (
      output i_tick, i_spike, i_lv, i_weight,
      input  o_addvalue, o_spike_out, o_trace, o_busy, o_sat, o_drop
   );
endinterface

// File: rtl/lv_decay_calc.sv
// rtl/lv_decay_calc.sv - combinational decay of the last value; exponential when LV_DECAY_EXP_EN is defined
module lv_decay_calc #(
   parameter int p_width     = 21,
   parameter int p_cnt_width = 16,
   parameter int p_decay     = 1,
   parameter int p_half_log2 = 4
) (
   input  logic [p_width-1:0]     i_lv,
   input  logic [p_cnt_width-1:0] i_elapsed,
   output logic [p_width-1:0]     o_decayed
);

`ifdef LV_DECAY_EXP_EN
   logic [p_cnt_width-1:0] k;
   logic [31:0]            unused_decay;

   assign unused_decay = p_decay;
   assign k            = i_elapsed >> p_half_log2;

   // one halving per 2^p_half_log2 ticks; past p_width halvings nothing is left
   always_comb begin
      o_decayed = '0;
      if (int'(k) < p_width)
         o_decayed = i_lv >> k;
   end
`else
   localparam int PW = p_cnt_width + p_width;

   logic [PW-1:0] prod;
   logic [31:0]   unused_half;

   assign unused_half = p_half_log2;
   assign prod        = PW'(i_elapsed) * PW'(p_decay);

   // full-width product so a long gap cannot wrap back into a nonzero value
   always_comb begin
      o_decayed = '0;
      if (prod < PW'(i_lv))
         o_decayed = i_lv - prod[p_width-1:0];
   end
`endif

endmodule

// File: rtl/lv_decay.sv
// rtl/lv_decay.sv - spike-driven trace update: decay, add weight, strobe into the last-value register
// Build option: define LV_DECAY_EXP_EN for exponential instead of linear decay.
module lv_decay
   import lv_pkg::*;
#(
   parameter int p_width     = LV_WIDTH,
   parameter int p_cnt_width = LV_CNT_WIDTH,
   parameter int p_decay     = 1,
   parameter int p_half_log2 = 4
) (
   input  logic   i_clk,
   input  logic   i_rst,
   lv_decay_if.slave bus
);

   localparam int STRB_W = (LV_STROBE_LEN > 1) ? $clog2(LV_STROBE_LEN) : 1;

   lv_state_t              state;
   logic [p_cnt_width-1:0] elapsed;
   logic [p_width-1:0]     decayed_c;
   logic [p_width-1:0]     decayed_q;
   logic [p_width:0]       sum;
   logic [p_width-1:0]     addvalue;
   logic                   spike_out;
   logic                   pending;
   logic                   drop;
   logic [STRB_W-1:0]      strb_cnt;
   logic                   busy;
   logic                   last_strobe;

   lv_decay_calc #(
      .p_width    (p_width),
      .p_cnt_width(p_cnt_width),
      .p_decay    (p_decay),
      .p_half_log2(p_half_log2)
   ) u_calc (
      .i_lv     (bus.i_lv),
      .i_elapsed(elapsed),
      .o_decayed(decayed_c)
   );

   assign busy        = (state != IDLE);
   assign sum         = {1'b0, decayed_q} + {1'b0, bus.i_weight};
   assign last_strobe = (state == STROBE) && (strb_cnt == STRB_W'(LV_STROBE_LEN - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         elapsed   <= '0;
         decayed_q <= '0;
         addvalue  <= '0;
         spike_out <= 1'b0;
         pending   <= 1'b0;
         drop      <= 1'b0;
         strb_cnt  <= '0;
      end else begin
         drop <= bus.i_spike && busy && pending;

         // the strobe edge restarts the elapsed time and beats any tick
         if (state == HOLD)
            elapsed <= '0;
         else if (bus.i_tick && (elapsed != '1))
            elapsed <= elapsed + 1'b1;

         if (bus.i_spike && busy && !pending)
            pending <= 1'b1;

         case (state)
            IDLE: begin
               if (bus.i_spike)
                  state <= CALC;
            end
            CALC: begin
               decayed_q <= decayed_c;
               state     <= ADD;
            end
            ADD: begin
               addvalue <= sum[p_width] ? '1 : sum[p_width-1:0];
               state    <= HOLD;
            end
            HOLD: begin
               spike_out <= 1'b1;
               strb_cnt  <= '0;
               state     <= STROBE;
            end
            STROBE: begin
               if (last_strobe) begin
                  spike_out <= 1'b0;
                  // a spike in this last cycle is served straight away
                  if (pending || bus.i_spike) begin
                     pending <= 1'b0;
                     state   <= CALC;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  strb_cnt <= strb_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_addvalue  = addvalue;
   assign bus.o_spike_out = spike_out;
   assign bus.o_trace     = decayed_c;
   assign bus.o_busy      = busy;
   assign bus.o_sat       = (state == ADD) && sum[p_width];
   assign bus.o_drop      = drop;

endmodule

// File: tb/tb_lv_decay.sv
// tb/tb_lv_decay.sv - self-checking bench for lv_decay: vector table, random vs. model, overlap and reset sequences
module tb_lv_decay;

   localparam int W = 21;
   localparam longint MAXV = (64'd1 << W) - 1;

   typedef struct {
      logic [W-1:0] lv;
      logic [W-1:0] w;
      int           ticks;
      logic [W-1:0] exp_val;
      logic         exp_sat;
   } vec_t;

   logic i_clk = 1'b0;
   logic i_rst;
   int   total = 0;
   int   bad   = 0;

   always #5 i_clk = ~i_clk;

   lv_decay_if #(.p_width(W)) bus ();

   lv_decay dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .bus  (bus)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   function automatic longint model_decay(longint lv, longint ticks);
`ifdef LV_DECAY_EXP_EN
      longint k = ticks / 16;
      if (k >= W) return 0;
      return lv / (64'd1 << k);
`else
      longint d = lv - ticks;
      return (d < 0) ? 0 : d;
`endif
   endfunction

   function automatic vec_t make_vec(longint lv, longint w, int ticks);
      vec_t   v;
      longint s = model_decay(lv, ticks) + w;
      v.lv      = W'(lv);
      v.w       = W'(w);
      v.ticks   = ticks;
      v.exp_sat = (s > MAXV);
      v.exp_val = (s > MAXV) ? W'(MAXV) : W'(s);
      return v;
   endfunction

   task automatic run_txn(input vec_t v, input string tag);
      for (int t = 0; t < v.ticks; t++) begin
         bus.i_tick = 1'b1;
         step();
      end
      bus.i_tick   = 1'b0;
      bus.i_lv     = v.lv;
      bus.i_weight = v.w;
      bus.i_spike  = 1'b1;
      step();
      bus.i_spike = 1'b0;
      chk({tag, " busy_calc"}, 64'(bus.o_busy), 64'd1);
      chk({tag, " sat_calc"}, 64'(bus.o_sat), 64'd0);
      step();
      chk({tag, " sat_add"}, 64'(bus.o_sat), 64'(v.exp_sat));
      step();
      chk({tag, " addvalue"}, 64'(bus.o_addvalue), 64'(v.exp_val));
      chk({tag, " strobe_hold"}, 64'(bus.o_spike_out), 64'd0);
      chk({tag, " sat_hold"}, 64'(bus.o_sat), 64'd0);
      step();
      chk({tag, " strobe1"}, 64'(bus.o_spike_out), 64'd1);
      chk({tag, " addvalue_s1"}, 64'(bus.o_addvalue), 64'(v.exp_val));
      step();
      chk({tag, " strobe2"}, 64'(bus.o_spike_out), 64'd1);
      chk({tag, " busy_s2"}, 64'(bus.o_busy), 64'd1);
      step();
      chk({tag, " strobe_end"}, 64'(bus.o_spike_out), 64'd0);
      chk({tag, " busy_end"}, 64'(bus.o_busy), 64'd0);
      chk({tag, " trace_cleared"}, 64'(bus.o_trace), 64'(v.lv));
      chk({tag, " drop"}, 64'(bus.o_drop), 64'd0);
   endtask

   vec_t         vecs[$];
   logic [19:0]  plan;
   logic         spk  [0:20];
   logic         drp  [0:20];
   logic         bsy  [0:20];
   logic [W-1:0] av   [0:20];
   int           n_hi;
   int           n_drop;

   initial begin
      i_rst        = 1'b1;
      bus.i_tick   = 1'b0;
      bus.i_spike  = 1'b0;
      bus.i_lv     = '0;
      bus.i_weight = '0;
      repeat (3) step();
      i_rst = 1'b0;

      // reset in idle after some ticks: counter must be back to 0
      bus.i_lv = W'(500);
      for (int t = 0; t < 10; t++) begin
         bus.i_tick = 1'b1;
         step();
      end
      bus.i_tick = 1'b0;
      i_rst      = 1'b1;
      step();
      step();
      i_rst = 1'b0;
      chk("rst addvalue", 64'(bus.o_addvalue), 64'd0);
      chk("rst spike_out", 64'(bus.o_spike_out), 64'd0);
      chk("rst busy", 64'(bus.o_busy), 64'd0);
      chk("rst sat", 64'(bus.o_sat), 64'd0);
      chk("rst drop", 64'(bus.o_drop), 64'd0);
      chk("rst trace", 64'(bus.o_trace), 64'd500);

`ifdef LV_DECAY_EXP_EN
      vecs.push_back('{lv: W'(1024), w: W'(0), ticks: 32,  exp_val: W'(256), exp_sat: 1'b0});
      vecs.push_back('{lv: W'(1024), w: W'(0), ticks: 400, exp_val: W'(0),   exp_sat: 1'b0});
`else
      vecs.push_back('{lv: W'(1000), w: W'(50), ticks: 100, exp_val: W'(950), exp_sat: 1'b0});
      vecs.push_back('{lv: W'(10),   w: W'(7),  ticks: 20,  exp_val: W'(7),   exp_sat: 1'b0});
`endif
      vecs.push_back('{lv: W'(MAXV), w: W'(5), ticks: 0, exp_val: W'(MAXV), exp_sat: 1'b1});
      vecs.push_back('{lv: W'(0),    w: W'(0), ticks: 3, exp_val: W'(0),    exp_sat: 1'b0});

      for (int i = 0; i < vecs.size(); i++)
         run_txn(vecs[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 8; i++) begin
         longint lv = longint'($urandom) & MAXV;
         longint w  = (i % 2 == 0) ? longint'($urandom_range(0, 1000))
                                   : (longint'($urandom) & MAXV);
         run_txn(make_vec(lv, w, $urandom_range(0, 300)), $sformatf("rnd%0d", i));
      end

      // overlap: spikes at 0, 2, 3 -> one pending, one dropped, two strobes
      bus.i_lv     = W'(100);
      bus.i_weight = W'(3);
      plan         = 20'b0000_0000_0000_0000_1101;
      for (int c = 0; c < 20; c++) begin
         bus.i_spike = plan[c];
         step();
         spk[c+1] = bus.o_spike_out;
         drp[c+1] = bus.o_drop;
         bsy[c+1] = bus.o_busy;
         av[c+1]  = bus.o_addvalue;
      end
      bus.i_spike = 1'b0;
      n_hi   = 0;
      n_drop = 0;
      for (int c = 1; c <= 20; c++) begin
         n_hi   += int'(spk[c]);
         n_drop += int'(drp[c]);
      end
      chk("ovl drop_at_4", 64'(drp[4]), 64'd1);
      chk("ovl drop_count", 64'(n_drop), 64'd1);
      chk("ovl strobe_cycles", 64'(n_hi), 64'd4);
      chk("ovl first_strobe", 64'({spk[4], spk[5]}), 64'd3);
      chk("ovl second_calc_busy", 64'({spk[6], bsy[6]}), 64'd1);
      chk("ovl second_strobe", 64'({spk[8], spk[9], spk[10], spk[11]}), 64'b0110);
      chk("ovl second_value", 64'(av[8]), 64'd103);
      chk("ovl idle_after", 64'(bsy[11]), 64'd0);

      // reset during the first strobe cycle with a spike pending
      plan = 20'b0000_0000_0000_0000_0101;
      for (int c = 0; c < 15; c++) begin
         bus.i_spike = plan[c];
         i_rst       = (c == 4);
         step();
         spk[c+1] = bus.o_spike_out;
         bsy[c+1] = bus.o_busy;
         av[c+1]  = bus.o_addvalue;
      end
      bus.i_spike = 1'b0;
      i_rst       = 1'b0;
      n_hi = 0;
      for (int c = 5; c <= 15; c++)
         n_hi += int'(spk[c]);
      chk("rstm strobe_before", 64'(spk[4]), 64'd1);
      chk("rstm strobe_cut", 64'(spk[5]), 64'd0);
      chk("rstm busy_cut", 64'(bsy[5]), 64'd0);
      chk("rstm addvalue_cut", 64'(av[5]), 64'd0);
      chk("rstm no_more_strobe", 64'(n_hi), 64'd0);
      chk("rstm idle_end", 64'(bsy[15]), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
